rf_write_arbiter: RTL and testbench

Shares the single register-file write port between two requesters: the in-order pipeline writeback and a long-latency (mul/div) result stream. Pipeline writeback has priority and passes through with zero added latency. Long-latency results are queued in a small FIFO and drained in idle WB slots. A starvation counter forces a pipeline stall so the queue always drains. The block also reports decode-stage hazards against queued, not-yet-written destinations. It sits between WB, the long-latency unit, the register file write port and the hazard detection logic in decode.

---
 rtl/rf_write_arbiter_if.sv | 36 +++
 rtl/rf_write_arbiter.sv | 109 ++++++++++
 tb/tb_rf_write_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - register-file write arbitration signal bundle
interface rf_write_arbiter_if;
  logic        in_wb_write_enable;
  logic [4:0]  in_wb_write_reg;
  logic [31:0] in_wb_write_data;
  logic        in_ll_valid;
  logic [4:0]  in_ll_rd;
  logic [31:0] in_ll_data;
  logic        out_ll_ready;
  logic [4:0]  in_IFID_rs1;
  logic [4:0]  in_IFID_rs2;
  logic [4:0]  in_IFID_rd;
  logic        out_ll_hazard;
  logic        out_stall_request;
  logic        out_write_enable;
  logic [4:0]  out_write_reg;
  logic [31:0] out_write_data;

  // Arbiter side
  modport slave (
    input  in_wb_write_enable, in_wb_write_reg, in_wb_write_data,
    input  in_ll_valid, in_ll_rd, in_ll_data,
    input  in_IFID_rs1, in_IFID_rs2, in_IFID_rd,
    output out_ll_ready, out_ll_hazard, out_stall_request,
    output out_write_enable, out_write_reg, out_write_data
  );

  // Pipeline / long-latency unit / register file side
  modport master (
    output in_wb_write_enable, in_wb_write_reg, in_wb_write_data,
    output in_ll_valid, in_ll_rd, in_ll_data,
    output in_IFID_rs1, in_IFID_rs2, in_IFID_rd,
    input  out_ll_ready, out_ll_hazard, out_stall_request,
    input  out_write_enable, out_write_reg, out_write_data
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port between WB and a long-latency result FIFO
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  rf_write_arbiter_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    r_rd   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_stall;

  logic          w_wb_req;
  logic          w_ready;
  logic          w_enq;
  logic          w_deq;
  logic          w_hazard;
  logic [AW-1:0] w_idx;
  logic          w_we;
  logic [4:0]    w_wreg;
  logic [31:0]   w_wdata;

  // x0 writes are dropped; everything is forced quiet while reset is held
  assign w_wb_req = !reset && bus.in_wb_write_enable && (bus.in_wb_write_reg != 5'd0);
  assign w_ready  = !reset && (r_count < CW'(DEPTH));
  assign w_enq    = bus.in_ll_valid && w_ready && (bus.in_ll_rd != 5'd0);
  assign w_deq    = !reset && (r_count != '0) && (!w_wb_req || r_stall);

  // FIFO storage; contents need no reset because count gates validity
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_rd[r_wptr]   <= bus.in_ll_rd;
      r_data[r_wptr] <= bus.in_ll_data;
    end
  end

  // Pointer, occupancy, starvation counter and stall flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
      if (w_deq || r_count == '0) begin
        r_starve <= '0;
      end else if (r_starve != SW'(STARVE_LIMIT)) begin
        r_starve <= r_starve + 1'b1;
      end
      if (w_deq) begin
        r_stall <= 1'b0;
      end else if (r_count != '0 && r_starve == SW'(STARVE_LIMIT)) begin
        r_stall <= 1'b1;
      end
    end
  end

  // Write-port mux: FIFO head when draining, else WB, else idle zeros
  always_comb begin
    w_we    = 1'b0;
    w_wreg  = 5'd0;
    w_wdata = 32'd0;
    if (w_deq) begin
      w_we    = 1'b1;
      w_wreg  = r_rd[r_rptr];
      w_wdata = r_data[r_rptr];
    end else if (w_wb_req) begin
      w_we    = 1'b1;
      w_wreg  = bus.in_wb_write_reg;
      w_wdata = bus.in_wb_write_data;
    end
  end

  // Decode hazard against every queued entry, including one draining this cycle
  always_comb begin
    w_hazard = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + AW'(i);
      if ((CW'(i) < r_count) && (r_rd[w_idx] != 5'd0) &&
          ((r_rd[w_idx] == bus.in_IFID_rs1) || (r_rd[w_idx] == bus.in_IFID_rs2) ||
           (r_rd[w_idx] == bus.in_IFID_rd))) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign bus.out_ll_ready      = w_ready;
  assign bus.out_stall_request = r_stall && !reset;
  assign bus.out_ll_hazard     = w_hazard && !reset;
  assign bus.out_write_enable  = w_we;
  assign bus.out_write_reg     = w_wreg;
  assign bus.out_write_data    = w_wdata;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ent_t q[$];
  int   m_starve = 0;
  bit   m_stall  = 1'b0;

  always #5 clk = ~clk;

  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs with the queue model at negedge, then advance the model at posedge.
  task automatic step(input string tag);
    logic        wb_req, exp_rdy, deq, haz, ewe;
    logic [4:0]  er;
    logic [31:0] ed;
    @(negedge clk);
    wb_req = bus.in_wb_write_enable && (bus.in_wb_write_reg != 5'd0);
    ewe = 1'b0; er = 5'd0; ed = 32'd0; haz = 1'b0;
    if (reset) begin
      exp_rdy = 1'b0;
      deq     = 1'b0;
    end else begin
      exp_rdy = (q.size() < DEPTH);
      deq     = (q.size() > 0) && (!wb_req || m_stall);
      if (deq) begin
        ewe = 1'b1; er = q[0].rd; ed = q[0].data;
      end else if (wb_req) begin
        ewe = 1'b1; er = bus.in_wb_write_reg; ed = bus.in_wb_write_data;
      end
      foreach (q[i])
        if (q[i].rd != 5'd0 && (q[i].rd == bus.in_IFID_rs1 || q[i].rd == bus.in_IFID_rs2 ||
                                q[i].rd == bus.in_IFID_rd)) haz = 1'b1;
    end
    chk({tag, ":we"},    32'(bus.out_write_enable),  32'(ewe));
    chk({tag, ":wreg"},  32'(bus.out_write_reg),     32'(er));
    chk({tag, ":wdata"}, bus.out_write_data,         ed);
    chk({tag, ":ready"}, 32'(bus.out_ll_ready),      32'(exp_rdy));
    chk({tag, ":stall"}, 32'(bus.out_stall_request), 32'(m_stall && !reset));
    chk({tag, ":haz"},   32'(bus.out_ll_hazard),     32'(haz));
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_starve = 0;
      m_stall  = 1'b0;
    end else begin
      bit was_nonempty;
      was_nonempty = (q.size() > 0);
      if (deq) void'(q.pop_front());
      if (bus.in_ll_valid && exp_rdy && bus.in_ll_rd != 5'd0)
        q.push_back('{rd: bus.in_ll_rd, data: bus.in_ll_data});
      if (deq) begin
        m_stall  = 1'b0;
        m_starve = 0;
      end else if (!was_nonempty) begin
        m_starve = 0;
      end else begin
        if (m_starve >= STARVE_LIMIT) m_stall = 1'b1;
        else m_starve++;
      end
    end
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.in_wb_write_enable = 1'b0; bus.in_wb_write_reg = 5'd0; bus.in_wb_write_data = 32'd0;
    bus.in_ll_valid = 1'b0; bus.in_ll_rd = 5'd0; bus.in_ll_data = 32'd0;
    bus.in_IFID_rs1 = 5'd0; bus.in_IFID_rs2 = 5'd0; bus.in_IFID_rd = 5'd0;

    // Reset held
    #2 chk("rst_ready", 32'(bus.out_ll_ready), 32'd0);
    step("rst0");
    step("rst1");
    reset = 1'b0;
    #2 chk("idle_ready", 32'(bus.out_ll_ready), 32'd1);
    chk("idle_we", 32'(bus.out_write_enable), 32'd0);
    step("idle");

    // WB pass-through and x0 drop
    bus.in_wb_write_enable = 1'b1; bus.in_wb_write_reg = 5'd5; bus.in_wb_write_data = 32'hDEADBEEF;
    #2 chk("wb_we", 32'(bus.out_write_enable), 32'd1);
    chk("wb_reg", 32'(bus.out_write_reg), 32'd5);
    chk("wb_data", bus.out_write_data, 32'hDEADBEEF);
    step("wb");
    bus.in_wb_write_reg = 5'd0;
    #2 chk("wb_x0_we", 32'(bus.out_write_enable), 32'd0);
    step("wbx0");
    bus.in_wb_write_enable = 1'b0;

    // LL single result with hazard on rs2
    bus.in_ll_valid = 1'b1; bus.in_ll_rd = 5'd7; bus.in_ll_data = 32'h12345678; bus.in_IFID_rs2 = 5'd7;
    #2 chk("ll_pre_we", 32'(bus.out_write_enable), 32'd0);
    step("ll_acc");
    bus.in_ll_valid = 1'b0;
    #2 chk("ll_haz_before", 32'(bus.out_ll_hazard), 32'd1);
    chk("ll_reg", 32'(bus.out_write_reg), 32'd7);
    chk("ll_data", bus.out_write_data, 32'h12345678);
    step("ll_wr");
    #2 chk("ll_haz_after", 32'(bus.out_ll_hazard), 32'd0);
    chk("ll_after_we", 32'(bus.out_write_enable), 32'd0);
    step("ll_done");
    bus.in_IFID_rs2 = 5'd0;

    // Fill under continuous WB, starvation forces a stall
    bus.in_wb_write_enable = 1'b1; bus.in_wb_write_reg = 5'd3; bus.in_wb_write_data = 32'hA5A5_0003;
    bus.in_ll_valid = 1'b1; bus.in_ll_rd = 5'd9; bus.in_ll_data = 32'h0000_0009;
    step("fill0");
    bus.in_ll_rd = 5'd10; bus.in_ll_data = 32'h0000_000A;
    step("fill1");
    bus.in_ll_rd = 5'd11; bus.in_ll_data = 32'h0000_000B;
    #2 chk("full_ready", 32'(bus.out_ll_ready), 32'd0);
    n = 0;
    while (!bus.out_stall_request && n < 20) begin
      step("starve");
      #2;
      n++;
    end
    chk("starve_cycles", n, 32'd4);
    chk("stall_we", 32'(bus.out_write_enable), 32'd1);
    chk("stall_reg", 32'(bus.out_write_reg), 32'd9);
    step("stall");
    #2 chk("post_stall_reg", 32'(bus.out_write_reg), 32'd3);
    chk("post_stall_ready", 32'(bus.out_ll_ready), 32'd1);
    chk("post_stall_flag", 32'(bus.out_stall_request), 32'd0);
    step("post_stall");
    bus.in_ll_valid = 1'b0; bus.in_wb_write_enable = 1'b0;
    for (int k = 0; k < 3; k++) step("drain");

    // Back-to-back results with WB idle: enqueue and dequeue together, across pointer wrap
    for (int k = 1; k <= 6; k++) begin
      bus.in_ll_valid = 1'b1; bus.in_ll_rd = 5'(k); bus.in_ll_data = 32'h1111 * k;
      #2 chk("seq_ready", 32'(bus.out_ll_ready), 32'd1);
      if (k > 1) chk("seq_reg", 32'(bus.out_write_reg), 32'(k - 1));
      step("seq");
    end
    bus.in_ll_valid = 1'b0;
    #2 chk("seq_last_reg", 32'(bus.out_write_reg), 32'd6);
    chk("seq_last_data", bus.out_write_data, 32'h1111 * 6);
    step("seq_last");

    // Reset with two entries queued discards them
    bus.in_wb_write_enable = 1'b1; bus.in_wb_write_reg = 5'd3;
    bus.in_ll_valid = 1'b1; bus.in_ll_rd = 5'd12;
    step("rq0");
    bus.in_ll_rd = 5'd13;
    step("rq1");
    reset = 1'b1; bus.in_ll_valid = 1'b0; bus.in_wb_write_enable = 1'b0;
    #2 chk("rq_rst_we", 32'(bus.out_write_enable), 32'd0);
    step("rq_rst");
    reset = 1'b0; bus.in_IFID_rs1 = 5'd12; bus.in_IFID_rs2 = 5'd13;
    #2 chk("rq_after_we", 32'(bus.out_write_enable), 32'd0);
    chk("rq_after_ready", 32'(bus.out_ll_ready), 32'd1);
    chk("rq_after_haz", 32'(bus.out_ll_hazard), 32'd0);
    step("rq_after");
    step("rq_after2");

    // Randomized traffic against the queue model; WB held stable while stalled
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (!m_stall) begin
        bus.in_wb_write_enable = ($urandom_range(0, 2) != 0);
        bus.in_wb_write_reg    = 5'($urandom_range(0, 7));
        bus.in_wb_write_data   = $urandom;
      end
      bus.in_ll_valid = 1'($urandom_range(0, 1));
      bus.in_ll_rd    = 5'($urandom_range(0, 7));
      bus.in_ll_data  = $urandom;
      bus.in_IFID_rs1 = 5'($urandom_range(0, 7));
      bus.in_IFID_rs2 = 5'($urandom_range(0, 7));
      bus.in_IFID_rd  = 5'($urandom_range(0, 7));
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
